s100_bus_cycle_ctrl: RTL
========================

# s100_bus_cycle_ctrl

Sequences single S-100 bus memory read and write cycles for the T35 on the FPGA SBC. It accepts one request at a time from on-chip logic, drives the 20-bit address, status and control strobes in the correct order, honours bus wait states via RDY, and returns read data or a timeout error. It owns the SBC address, status and control output-enable pins, so no other logic drives those buses.

## Interface
- STROBE_MIN, 2: minimum cycles pDBIN/n_pWR held active before RDY is sampled (1..15)
- TIMEOUT, 255: maximum wait cycles with RDY low before abort (1..255)
- pll0_2MHz  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req  in  1  request valid; held with fields stable until ack
- req_wr  in  1  1 = memory write, 0 = memory read
- req_addr  in  20  bus address A19..A0
- req_wdata  in  8  write data
- ack  out  1  one-cycle pulse: request accepted and finished
- rdata  out  8  read data, valid in the ack cycle, held until next ack
- err  out  1  with ack: cycle aborted by timeout
- busy  out  1  high from acceptance until the ack cycle
- RDY  in  1  S-100 ready; low inserts wait states
- S100adr0_15  out  16  A15..A0
- S100adr16_19  out  4  board wired reversed: bit0=A19, bit3=A16
- S100dout  out  8  data out bus; S100din  in  8  data in bus
- pSYNC, pSTVAL, pDBIN, n_pWR, sMWRT  out  1 each  bus strobes/status
- F_add_oe, F_bus_stat_oe, F_bus_ctl_oe  out  1 each  active-low driver enables

## Operation
- States: IDLE, SYNC, STVAL, STROBE, WAIT, HOLD.
- IDLE: busy=0; if req, latch req_wr/addr/wdata, go SYNC. Address is held in internal registers, so the requester may change req fields after ack.
- SYNC: pSYNC=1, status valid (sMWRT=req_wr), address driven -> STVAL.
- STVAL: pSYNC=1, pSTVAL=0 (low pulse) -> STROBE.
- STROBE: read: pDBIN=1; write: n_pWR=0, S100dout=wdata. Counter runs STROBE_MIN cycles, then -> WAIT.
- WAIT: strobe held; if RDY=1 -> HOLD; otherwise wait counter increments; at count==TIMEOUT -> HOLD with err set.
- HOLD: strobes deasserted; read captures S100din into rdata (unless err); ack=1 -> IDLE.
- Idle bus levels: pSYNC=0, pSTVAL=1, pDBIN=0, n_pWR=1, sMWRT=0, address holds last value, S100dout=0.
- OE: F_add_oe, F_bus_stat_oe, F_bus_ctl_oe = 0 (enabled) whenever out of reset; 1 during reset.
- Back-to-back: req high in the ack cycle is not accepted; the earliest next acceptance is the following IDLE cycle.
- Wait counter is 8 bits; it saturates and never wraps.

## Timing
- All outputs registered; reset values: ack=0, err=0, busy=0, rdata=0, address=0, S100dout=0, strobes at idle levels, OEs=1.
- Read with RDY high throughout: req sampled at cycle 0 -> SYNC 1, STVAL 2, STROBE 3..(2+STROBE_MIN), WAIT 1 cycle, HOLD/ack at cycle 4+STROBE_MIN (6 with defaults).
- Each low-RDY cycle in WAIT adds one cycle; RDY is sampled only in WAIT.
- Timeout: ack/err at cycle 4+STROBE_MIN+TIMEOUT when RDY stays low.
- Reset mid-cycle: next edge forces IDLE and idle levels, no ack, request discarded.
- req and reset together: reset wins.

## Structure
- Shared package s100_pkg: state encoding constants, idle strobe levels, and the A16..A19 bit-reversal function (reused by other bus masters).
- One sub-module is natural: s100_wait_timer (load/count/saturate, flags min_done and timeout), instantiated once.
- FSM, address/data registers and output registers stay in the top module.

## Test plan
- Read, RDY=1, addr 0x12345, S100din=0xA5 -> pSYNC high cycles 1-2, pSTVAL low cycle 2, pDBIN high cycles 3-5, ack cycle 6, rdata=0xA5, err=0, S100adr0_15=0x2345, S100adr16_19=4'b1000.
- Write addr 0xFFFFF, data 0x3C -> sMWRT=1 cycles 1-5, n_pWR low cycles 3-5, S100dout=0x3C during strobe, ack cycle 6.
- Read with RDY low for 3 WAIT cycles -> ack at cycle 9, pDBIN held through cycle 8, data captured after RDY rises.
- RDY held low, TIMEOUT=4 -> ack with err=1 at cycle 10, rdata unchanged from prior value.
- Reset asserted in STROBE -> next cycle: all strobes idle, busy=0, OEs=1, no ack; after release, a new req completes normally.
- req held high continuously -> consecutive acks exactly 7 cycles apart, each with freshly latched fields.

Source files
------------

// File: rtl/s100_pkg.sv
// Shared S-100 bus-master definitions: cycle state encoding, idle strobe
// levels and the A16..A19 pin-order helper for the reversed header wiring.
package s100_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_STVAL  = 3'd2,
        ST_STROBE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_HOLD   = 3'd5
    } bus_state_t;

    localparam logic IDLE_PSYNC  = 1'b0;
    localparam logic IDLE_PSTVAL = 1'b1;
    localparam logic IDLE_PDBIN  = 1'b0;
    localparam logic IDLE_NPWR   = 1'b1;
    localparam logic IDLE_SMWRT  = 1'b0;

    localparam int WAIT_CNT_W = 8;

    // The board routes A19 to pin bit 0 and A16 to pin bit 3.
    function automatic logic [3:0] adr_hi_reverse(input logic [3:0] a19_16);
        return {a19_16[0], a19_16[1], a19_16[2], a19_16[3]};
    endfunction

endpackage

// File: rtl/s100_wait_timer.sv
// Shared strobe/wait counter: cleared by load, counts up on en, saturates
// at all-ones so a long RDY-low stretch can never wrap back to zero.
module s100_wait_timer #(
    parameter int STROBE_MIN = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic pll0_2MHz,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic min_done,
    output logic timeout
);
    import s100_pkg::*;

    logic [WAIT_CNT_W-1:0] cnt;

    // Counter register: load has priority over counting.
    always_ff @(posedge pll0_2MHz) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && (cnt != {WAIT_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Count starts at 0 on the first strobe cycle, so the last one sees MIN-1.
    assign min_done = (cnt == WAIT_CNT_W'(STROBE_MIN - 1));
    assign timeout  = (cnt == WAIT_CNT_W'(TIMEOUT));

endmodule

// File: rtl/s100_bus_cycle_ctrl.sv
// Single-transfer S-100 memory read/write cycle sequencer with RDY wait
// states and timeout abort. Outputs are registered from the next state so
// they line up with the state they belong to.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | bus idle, waiting for req
// ST_SYNC   | pSYNC high, status and address valid
// ST_STVAL  | pSYNC high, pSTVAL low pulse
// ST_STROBE | pDBIN / n_pWR active for STROBE_MIN cycles
// ST_WAIT   | strobe held, sampling RDY, counting wait states
// ST_HOLD   | strobes released, ack (and err on timeout)
module s100_bus_cycle_ctrl #(
    parameter int STROBE_MIN = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        pll0_2MHz,
    input  logic        reset,
    input  logic        req,
    input  logic        req_wr,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        busy,
    input  logic        RDY,
    output logic [15:0] S100adr0_15,
    output logic [3:0]  S100adr16_19,
    output logic [7:0]  S100dout,
    input  logic [7:0]  S100din,
    output logic        pSYNC,
    output logic        pSTVAL,
    output logic        pDBIN,
    output logic        n_pWR,
    output logic        sMWRT,
    output logic        F_add_oe,
    output logic        F_bus_stat_oe,
    output logic        F_bus_ctl_oe
);
    import s100_pkg::*;

    bus_state_t  state, next_state;
    logic        wr_q;
    logic [19:0] addr_q;
    logic [7:0]  wdata_q;

    logic accept, capture, abort;
    logic tmr_load, tmr_en, min_done, timeout;
    logic wr_next, strobe_next, sync_next, status_next;

    s100_wait_timer #(
        .STROBE_MIN(STROBE_MIN),
        .TIMEOUT   (TIMEOUT)
    ) u_wait_timer (
        .pll0_2MHz(pll0_2MHz),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .min_done (min_done),
        .timeout  (timeout)
    );

    // State register.
    always_ff @(posedge pll0_2MHz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    next_state = ST_SYNC;
                end
            end
            ST_SYNC: begin
                next_state = ST_STVAL;
            end
            ST_STVAL: begin
                tmr_load   = 1'b1;
                next_state = ST_STROBE;
            end
            ST_STROBE: begin
                if (min_done) begin
                    tmr_load   = 1'b1;
                    next_state = ST_WAIT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT: begin
                // RDY wins over a timeout landing in the same cycle.
                if (RDY) begin
                    capture    = ~wr_q;
                    next_state = ST_HOLD;
                end else if (timeout) begin
                    abort      = 1'b1;
                    next_state = ST_HOLD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_HOLD: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // On the accepting edge the latched direction is not yet visible.
    assign wr_next     = accept ? req_wr : wr_q;
    assign strobe_next = (next_state == ST_STROBE) || (next_state == ST_WAIT);
    assign sync_next   = (next_state == ST_SYNC) || (next_state == ST_STVAL);
    assign status_next = sync_next || strobe_next;

    // Request fields are captured once so the requester is free after ack.
    always_ff @(posedge pll0_2MHz) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Registered bus strobes, status, handshake and driver enables.
    always_ff @(posedge pll0_2MHz) begin
        if (reset) begin
            pSYNC         <= IDLE_PSYNC;
            pSTVAL        <= IDLE_PSTVAL;
            pDBIN         <= IDLE_PDBIN;
            n_pWR         <= IDLE_NPWR;
            sMWRT         <= IDLE_SMWRT;
            S100dout      <= '0;
            ack           <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            rdata         <= '0;
            F_add_oe      <= 1'b1;
            F_bus_stat_oe <= 1'b1;
            F_bus_ctl_oe  <= 1'b1;
        end else begin
            pSYNC         <= sync_next;
            pSTVAL        <= (next_state != ST_STVAL);
            pDBIN         <= strobe_next && !wr_next;
            n_pWR         <= !(strobe_next && wr_next);
            sMWRT         <= status_next && wr_next;
            S100dout      <= (strobe_next && wr_next) ? wdata_q : 8'h00;
            ack           <= (next_state == ST_HOLD);
            err           <= abort;
            busy          <= (next_state != ST_IDLE);
            F_add_oe      <= 1'b0;
            F_bus_stat_oe <= 1'b0;
            F_bus_ctl_oe  <= 1'b0;
            if (capture) begin
                rdata <= S100din;
            end
        end
    end

    assign S100adr0_15  = addr_q[15:0];
    assign S100adr16_19 = adr_hi_reverse(addr_q[19:16]);

endmodule
